// File: rtl/cnt_chk_pkg.sv
// Shared types and constants for the count-sequence checker.
package cnt_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_ERR   = 2'd2
   } state_e;

   localparam logic [1:0] EVT_WRAP = 2'b01;
   localparam logic [1:0] EVT_ERR  = 2'b10;

   localparam int CNT_W_DEF      = 2;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam int SAT_W_DEF      = 8;

endpackage

// File: rtl/evt_fifo.sv
// First-word-fall-through event FIFO with a sticky overflow flag.
module evt_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             drop
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q;
   logic [AW:0]      rd_q;
   logic             drop_q;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_comb begin
      empty   = (wr_q == rd_q);
      full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         drop_q <= 1'b0;
      end else begin
         if (do_push) wr_q <= wr_q + (AW+1)'(1);
         if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
         if (clr)
            drop_q <= 1'b0;
         else if (push && !do_push)
            drop_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
   end

   assign drop = drop_q;

endmodule

// File: rtl/cnt_seq_checker.sv
// Monitors an upstream counter for legal +1 sequencing, counts wraps and
// errors, and queues wrap/error events for a downstream consumer.
module cnt_seq_checker
   import cnt_chk_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int SAT_W      = SAT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [CNT_W-1:0]   cnt_in,
   input  logic               cnt_vld,
   input  logic               clr,
   output logic               wrap_pulse,
   output logic [SAT_W-1:0]   wrap_count,
   output logic               err,
   output logic [SAT_W-1:0]   err_count,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [CNT_W+1:0]   evt_data,
   output logic               evt_drop
);

   localparam int EVT_W = CNT_W + 2;

   state_e             state_q;
   logic [CNT_W-1:0]   exp_q;
   logic [CNT_W-1:0]   exp_d;
   logic               wrap_pulse_q;
   logic [SAT_W-1:0]   wrap_cnt_q;
   logic               err_q;
   logic [SAT_W-1:0]   err_cnt_q;
   logic               push_q;
   logic [EVT_W-1:0]   push_data_q;
   logic               match;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_drop;

   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
      return (&v) ? v : v + SAT_W'(1);
   endfunction

   always_comb begin
      exp_d = cnt_in + CNT_W'(1);
      match = (cnt_in == exp_q);
   end

   // Detection stage: results register here, the FIFO write follows one edge later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         exp_q        <= '0;
         wrap_pulse_q <= 1'b0;
         wrap_cnt_q   <= '0;
         err_q        <= 1'b0;
         err_cnt_q    <= '0;
         push_q       <= 1'b0;
      end else if (clr) begin
         state_q      <= ST_IDLE;
         exp_q        <= '0;
         wrap_pulse_q <= 1'b0;
         wrap_cnt_q   <= '0;
         err_q        <= 1'b0;
         err_cnt_q    <= '0;
         push_q       <= 1'b0;
      end else begin
         wrap_pulse_q <= 1'b0;
         push_q       <= 1'b0;
         if (cnt_vld) begin
            exp_q <= exp_d;
            if (state_q == ST_IDLE) begin
               state_q <= ST_TRACK;
            end else if (match) begin
               if (cnt_in == '0) begin
                  wrap_pulse_q <= 1'b1;
                  wrap_cnt_q   <= sat_inc(wrap_cnt_q);
                  push_q       <= 1'b1;
               end
            end else begin
               state_q   <= ST_ERR;
               err_q     <= 1'b1;
               err_cnt_q <= sat_inc(err_cnt_q);
               push_q    <= 1'b1;
            end
         end
      end
   end

   // Event payload is pure data; its qualifier push_q carries the reset.
   always_ff @(posedge clk) begin
      if (cnt_vld && match && cnt_in == '0)
         push_data_q <= {EVT_WRAP, {CNT_W{1'b0}}};
      else
         push_data_q <= {EVT_ERR, cnt_in};
   end

   evt_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_evt_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .push  (push_q),
      .wdata (push_data_q),
      .full  (fifo_full),
      .pop   (evt_ready),
      .rdata (evt_data),
      .empty (fifo_empty),
      .drop  (fifo_drop)
   );

   a_full_not_empty : assert property (@(posedge clk) disable iff (rst) fifo_full |-> !fifo_empty);

   assign wrap_pulse = wrap_pulse_q;
   assign wrap_count = wrap_cnt_q;
   assign err        = err_q;
   assign err_count  = err_cnt_q;
   assign evt_valid  = !fifo_empty;
   assign evt_drop   = fifo_drop;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed bench for cnt_seq_checker with a queue-based reference model.
module tb_cnt_seq_checker;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] cnt_in = '0;
   logic       cnt_vld = 1'b0;
   logic       clr = 1'b0;
   logic       evt_ready = 1'b0;
   logic       wrap_pulse;
   logic [7:0] wrap_count;
   logic       err;
   logic [7:0] err_count;
   logic       evt_valid;
   logic [3:0] evt_data;
   logic       evt_drop;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state
   bit m_started = 0;
   int m_exp     = 0;
   bit m_pulse   = 0;
   int m_wc      = 0;
   int m_ec      = 0;
   bit m_err     = 0;
   bit m_drop    = 0;
   bit m_pend_v  = 0;
   int m_pend    = 0;
   int m_q[$];

   cnt_seq_checker #(.CNT_W(2), .FIFO_DEPTH(DEPTH), .SAT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .cnt_in     (cnt_in),
      .cnt_vld    (cnt_vld),
      .clr        (clr),
      .wrap_pulse (wrap_pulse),
      .wrap_count (wrap_count),
      .err        (err),
      .err_count  (err_count),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_data   (evt_data),
      .evt_drop   (evt_drop)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, need finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, need %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: events from one sampling edge enter the queue on the following edge.
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_started = 0; m_exp = 0; m_pulse = 0; m_wc = 0; m_ec = 0;
         m_err = 0; m_drop = 0; m_pend_v = 0; m_q.delete();
      end else begin
         if (evt_ready && m_q.size() > 0) void'(m_q.pop_front());
         if (m_pend_v) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_pend);
            else m_drop = 1;
         end
         m_pend_v = 0;
         m_pulse  = 0;
         if (clr) begin
            m_started = 0; m_err = 0; m_wc = 0; m_ec = 0; m_drop = 0;
         end else if (cnt_vld) begin
            if (m_started) begin
               if (int'(cnt_in) == m_exp) begin
                  if (cnt_in == 2'd0) begin
                     m_pulse = 1;
                     if (m_wc < 255) m_wc++;
                     m_pend_v = 1;
                     m_pend = 4'b0100;
                  end
               end else begin
                  m_err = 1;
                  if (m_ec < 255) m_ec++;
                  m_pend_v = 1;
                  m_pend = 8 + int'(cnt_in);
               end
            end
            m_started = 1;
            m_exp = (int'(cnt_in) + 1) % 4;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("wrap_pulse", 32'(wrap_pulse), 32'(m_pulse));
         chk("wrap_count", 32'(wrap_count), 32'(m_wc));
         chk("err", 32'(err), 32'(m_err));
         chk("err_count", 32'(err_count), 32'(m_ec));
         chk("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
         chk("evt_drop", 32'(evt_drop), 32'(m_drop));
         if (m_q.size() > 0) chk("evt_data", 32'(evt_data), 32'(m_q[0]));
      end
   end

   task automatic step(input bit v, input int c);
      cnt_vld = v;
      cnt_in  = c[1:0];
      @(negedge clk);
   endtask

   task automatic do_clr();
      cnt_vld = 1'b0;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic pop_expect(input string nm, input int exp);
      chk(nm, 32'(evt_data), 32'(exp));
      evt_ready = 1'b1;
      step(0, 0);
      evt_ready = 1'b0;
   endtask

   initial begin
      int pops[4];
      repeat (2) @(negedge clk);
      chk("rst_wrap_pulse", 32'(wrap_pulse), 0);
      chk("rst_wrap_count", 32'(wrap_count), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_evt_valid", 32'(evt_valid), 0);
      chk("rst_evt_data", 32'(evt_data), 0);
      rst = 1'b0;

      // legal sequence with one wrap
      step(1, 0); step(1, 1); step(1, 2); step(1, 3);
      chk("seq_no_pulse_yet", 32'(wrap_pulse), 0);
      step(1, 0);
      chk("seq_wrap_pulse", 32'(wrap_pulse), 1);
      chk("seq_wrap_count", 32'(wrap_count), 1);
      chk("seq_evt_not_yet", 32'(evt_valid), 0);
      step(1, 1);
      chk("seq_pulse_one_cycle", 32'(wrap_pulse), 0);
      chk("seq_err", 32'(err), 0);
      chk("seq_evt_valid", 32'(evt_valid), 1);
      pop_expect("seq_evt_data", 4'b0100);
      chk("seq_evt_empty", 32'(evt_valid), 0);
      step(0, 0);

      // sequence error then a legal wrap while in ERR
      do_clr();
      step(1, 0); step(1, 1); step(1, 3);
      chk("err_flag", 32'(err), 1);
      chk("err_count", 32'(err_count), 1);
      step(1, 0);
      chk("err_wrap_pulse", 32'(wrap_pulse), 1);
      chk("err_wrap_count", 32'(wrap_count), 1);
      chk("err_sticky", 32'(err), 1);
      step(0, 0);
      pop_expect("err_evt0", 4'b1011);
      pop_expect("err_evt1", 4'b0100);
      chk("err_evt_empty", 32'(evt_valid), 0);

      // overflow: five wraps into a four-entry FIFO
      do_clr();
      step(1, 3);
      for (int w = 0; w < 5; w++) begin
         step(1, 0);
         if (w < 4) begin step(1, 1); step(1, 2); step(1, 3); end
      end
      step(0, 0); step(0, 0);
      chk("ovf_drop", 32'(evt_drop), 1);
      chk("ovf_wrap_count", 32'(wrap_count), 5);
      for (int i = 0; i < 4; i++) pop_expect("ovf_pop", 4'b0100);
      chk("ovf_empty", 32'(evt_valid), 0);

      // full FIFO with simultaneous push and pop
      do_clr();
      chk("full_drop_cleared", 32'(evt_drop), 0);
      step(1, 0); step(1, 2); step(1, 0); step(1, 2); step(1, 1);
      step(0, 0);
      chk("full_head", 32'(evt_data), 4'b1010);
      step(1, 3);
      evt_ready = 1'b1;
      step(0, 0);
      evt_ready = 1'b0;
      chk("full_pp_drop", 32'(evt_drop), 0);
      chk("full_err_count", 32'(err_count), 5);
      pops[0] = 4'b1000; pops[1] = 4'b1010; pops[2] = 4'b1001; pops[3] = 4'b1011;
      for (int i = 0; i < 4; i++) pop_expect("full_pop_order", pops[i]);
      chk("full_empty", 32'(evt_valid), 0);

      // clr colliding with a valid sample while in ERR
      clr = 1'b1; cnt_vld = 1'b1; cnt_in = 2'd2;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_err", 32'(err), 0);
      chk("clr_err_count", 32'(err_count), 0);
      chk("clr_wrap_count", 32'(wrap_count), 0);
      step(1, 0);
      chk("clr_reload_only", 32'(err), 0);
      step(1, 1);
      chk("clr_track", 32'(err), 0);

      // wrap counter saturation, then asynchronous reset mid-stream
      do_clr();
      evt_ready = 1'b1;
      step(1, 3);
      for (int w = 0; w < 255; w++) begin
         step(1, 0); step(1, 1); step(1, 2); step(1, 3);
      end
      chk("sat_at_max", 32'(wrap_count), 255);
      step(0, 0); step(0, 0);
      evt_ready = 1'b0;
      step(1, 0);
      chk("sat_pulse", 32'(wrap_pulse), 1);
      chk("sat_hold", 32'(wrap_count), 255);
      step(1, 1);
      chk("sat_evt_data", 32'(evt_data), 4'b0100);
      #2 rst = 1'b1;
      #1;
      chk("arst_wrap_count", 32'(wrap_count), 0);
      chk("arst_wrap_pulse", 32'(wrap_pulse), 0);
      chk("arst_evt_valid", 32'(evt_valid), 0);
      chk("arst_evt_data", 32'(evt_data), 0);
      chk("arst_err_count", 32'(err_count), 0);
      @(negedge clk);
      rst = 1'b0;
      step(1, 2); step(1, 3);
      chk("post_rst_track", 32'(err), 0);
      step(1, 0);
      chk("post_rst_wrap", 32'(wrap_count), 1);
      step(0, 0); step(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cnt_seq_checker.md
CNT_SEQ_CHECKER -- requirements
Module: cnt_seq_checker

Interface
REQ-001 Parameter CNT_W, default 2, width of the monitored count.
REQ-002 Parameter FIFO_DEPTH, default 4, event FIFO entries (power of two, >=2).
REQ-003 Parameter SAT_W, default 8, width of the wrap and error counters.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cnt_in  input  CNT_W  count value from the upstream counter.
REQ-007 cnt_vld  input  1  cnt_in is sampled only when high.
REQ-008 clr  input  1  synchronous clear of err, counters and tracking state.
REQ-009 wrap_pulse  output  1  one-cycle pulse per legal wrap (max -> 0).
REQ-010 wrap_count  output  SAT_W  saturating count of legal wraps.
REQ-011 err  output  1  sticky sequence-error flag.
REQ-012 err_count  output  SAT_W  saturating count of mismatches.
REQ-013 evt_valid  output  1  event FIFO head is valid.
REQ-014 evt_ready  input  1  consumer accepts head when high with evt_valid.
REQ-015 evt_data  output  CNT_W+2  {type[1:0], value[CNT_W-1:0]}; type 01 = wrap, 10 = error.
REQ-016 evt_drop  output  1  sticky flag, event lost because FIFO was full.

Function
REQ-017 FSM states IDLE, TRACK, ERR; the FSM SHALL leave IDLE only on a valid sample.
REQ-018 IDLE + cnt_vld: load expected = cnt_in+1 mod 2^CNT_W, go TRACK; no check, no event.
REQ-019 TRACK/ERR + cnt_vld: compare cnt_in to expected, then set expected = cnt_in+1 mod 2^CNT_W (resync on mismatch).
REQ-020 Match with cnt_in==0: wrap_pulse high for exactly the cycle after the sampling edge; wrap_count +1, saturating at 2^SAT_W-1; push wrap event with value 0.
REQ-021 Mismatch: err set, state -> ERR, err_count +1 saturating, push error event carrying the received cnt_in.
REQ-022 ERR SHALL keep checking; further mismatches increment err_count and push events; ERR exits only via clr or rst.
REQ-023 cnt_vld low: expected, state and counters hold; wrap_pulse low.
REQ-024 clr: state -> IDLE; err, err_count, wrap_count, evt_drop -> 0; the same-cycle sample SHALL be discarded (clr wins); FIFO contents are kept.
REQ-025 Detection results register at sampling edge N; FIFO write at edge N+1; evt_valid high after edge N+1 when previously empty.
REQ-026 FIFO is first-word-fall-through; evt_data SHALL be stable while evt_valid && !evt_ready.
REQ-027 Pop on evt_valid && evt_ready; push and pop in the same cycle SHALL both occur, including when full.
REQ-028 Push while full without pop: event discarded, evt_drop set, FIFO unchanged.
REQ-029 Empty FIFO: evt_valid low; evt_data is a don't-care.

Reset
REQ-030 rst asserted SHALL immediately force state IDLE, FIFO empty, and all outputs to 0 (evt_data included), independent of clk.
REQ-031 Reset mid-operation SHALL discard in-flight detections and FIFO contents; the first valid sample after deassertion follows REQ-018.

Structure
REQ-032 Package cnt_chk_pkg SHALL hold the FSM state enum, event type codes (EVT_WRAP = 2'b01, EVT_ERR = 2'b10) and default parameter values.
REQ-033 FIFO SHALL be a sub-module evt_fifo (parameters WIDTH, DEPTH; push/full, pop/empty, drop).

Verification
REQ-034 Reset, then cnt_in 0,1,2,3,0,1 with cnt_vld=1 -> one wrap_pulse after the fifth sample, wrap_count=1, err=0, one event {01,00}.
REQ-035 cnt_in 0,1,3 -> err=1 after third sample, err_count=1, event {10,11}; then 0 -> legal wrap, wrap_count=1, state stays ERR.
REQ-036 evt_ready=0, generate 5 wraps with FIFO_DEPTH=4 -> 4 events held, evt_drop=1; with evt_ready=1, 4 pops in order.
REQ-037 FIFO full plus simultaneous event and evt_ready=1 -> pop and push both occur, still 4 entries, evt_drop unchanged.
REQ-038 clr and cnt_vld in the same cycle while err=1 -> err=0, counters 0, state IDLE, next sample only reloads expected.
REQ-039 Force wrap_count to 255 (SAT_W=8), one more wrap -> wrap_count stays 255, wrap_pulse still pulses; rst mid-stream -> all outputs 0 asynchronously.
